// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky overflow/underflow.
// Registered data_out one cycle after an accepted read; SYNC_FIFO_FWFT_EN shows the head word combinationally instead.
// Writes are dropped while full and reads are ignored while empty; each case sets a sticky error flag.
module sync_fifo #(
  parameter int FIFO_DEPTH    = 16,
  parameter int FIFO_WIDTH    = 16,
  parameter int PTR_WIDTH     = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] AFULL_LVL  = (PTR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_LVL = (PTR_WIDTH+1)'(AEMPTY_THRESH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH:0]    b_wptr;
  logic [PTR_WIDTH:0]    b_rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Full/empty come from the registered pointers only, so a same-cycle read never frees room for a write.
  assign fifo_empty   = (b_wptr == b_rptr);
  assign fifo_full    = (b_wptr[PTR_WIDTH] != b_rptr[PTR_WIDTH]) &&
                        (b_wptr[PTR_WIDTH-1:0] == b_rptr[PTR_WIDTH-1:0]);
  assign fifo_count   = b_wptr - b_rptr;
  assign almost_full  = (fifo_count >= AFULL_LVL);
  assign almost_empty = (fifo_count <= AEMPTY_LVL);

  assign wr_acc = wr_en && !fifo_full;
  assign rd_acc = rd_en && !fifo_empty;

  // Storage carries no reset; every location is written before it can be read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[b_wptr[PTR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wptr    <= '0;
      b_rptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) b_wptr <= b_wptr + 1'b1;
      if (rd_acc) b_rptr <= b_rptr + 1'b1;
      // A new error event takes priority over a clear in the same cycle.
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd_en && fifo_empty) underflow <= 1'b1;
      else if (clr_err)        underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = fifo_empty ? '0 : mem[b_rptr[PTR_WIDTH-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[b_rptr[PTR_WIDTH-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: driver updates a reference queue, monitor compares every cycle on the falling edge.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] data_out;
  logic        fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0]  fifo_count;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] last_dout = '0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic        rd_mon = 1'b0;

  sync_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference model on the same edge as the DUT.
  task automatic do_cycle(input logic w, input logic [15:0] d, input logic r, input logic c);
    logic m_full, m_empty;
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    m_full  = (m_q.size() == 16);
    m_empty = (m_q.size() == 0);
    if (w && m_full) m_ovf = 1'b1;
    else if (c)      m_ovf = 1'b0;
    if (r && m_empty) m_udf = 1'b1;
    else if (c)       m_udf = 1'b0;
    if (r && !m_empty) begin
      exp_q.push_back(m_q.pop_front());
      rd_mon = 1'b1;
    end
    if (w && !m_full) m_q.push_back(d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  // Monitor: status every cycle; read data popped from the scoreboard when a read was accepted.
  always @(negedge clk) begin
    chk("count", fifo_count, m_q.size());
    chk("empty", fifo_empty, m_q.size() == 0);
    chk("full", fifo_full, m_q.size() == 16);
    chk("almost_full", almost_full, m_q.size() >= 12);
    chk("almost_empty", almost_empty, m_q.size() <= 4);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
`ifdef SYNC_FIFO_FWFT_EN
    rd_mon = 1'b0;
    exp_q.delete();
    chk("fwft_data", data_out, (m_q.size() == 0) ? 0 : m_q[0]);
`else
    if (rd_mon) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: read observed with empty expected queue at %0t", $time);
      end else begin
        last_dout = exp_q.pop_front();
      end
      rd_mon = 1'b0;
    end
    chk("data_out", data_out, last_dout);
`endif
  end

  initial begin
    // Reset held from time zero
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Mid-operation reset with a write in flight discards everything at once
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    wr_en = 1'b1; data_in = 16'hDEAD;
    rst_n = 1'b0;
    #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    m_q.delete(); exp_q.delete(); rd_mon = 1'b0; last_dout = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 wr_en = 1'b0; rst_n = 1'b1;

    // Fill with 0x0001..0x0010, then one extra write overflows
    for (int i = 1; i <= 17; i++) do_cycle(1'b1, 16'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_count", fifo_count, 16);
    chk("fill_full", fifo_full, 1);
    chk("fill_ovf", overflow, 1);

    // Drain all 16, then one extra read underflows
    for (int i = 1; i <= 17; i++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_empty", fifo_empty, 1);
    chk("drain_udf", underflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_hold", data_out, 16'h0010);
`endif
    do_cycle(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    // Steady state at count 8 with simultaneous read/write over 40 cycles
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    for (int i = 8; i < 48; i++) do_cycle(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    @(negedge clk);
    chk("steady_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Full with read+write+clear together: read wins, write rejected, overflow still set
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    do_cycle(1'b1, 16'hBEEF, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_rw_count", fifo_count, 15);
    chk("full_rw_ovf", overflow, 1);
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b0, 1'b1);

    // Single word into an empty FIFO
    do_cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
    @(negedge clk);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_show", data_out, 16'hABCD);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fwft_pop_empty", fifo_empty, 1);
    chk("fwft_pop_dout", data_out, 0);
`else
    chk("std_no_fall", data_out, 16'h020F);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("std_read", data_out, 16'hABCD);
    chk("std_empty", fifo_empty, 1);
`endif

    do_cycle(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
